// File: rtl/backprop_sequencer.sv
// Output-layer weight-update sequencer: walks every hidden neuron through the shared datapath.
// Optional BP_SEQ_SKIP_ZERO_EN: neurons with a zero hidden activation bypass the datapath.
module backprop_sequencer #(
    parameter int N_HIDDEN = 4,
    parameter int W_WIDTH  = 8,
    parameter int H_WIDTH  = 10,
    parameter int TIMEOUT  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [3:0]                   target_i,
    input  logic [22:0]                  final_i,
    input  logic [N_HIDDEN*H_WIDTH-1:0]  hidden_vals_i,
    input  logic                         wr_en_i,
    input  logic [2:0]                   wr_addr_i,
    input  logic [W_WIDTH-1:0]           wr_data_i,
    input  logic [2:0]                   rd_addr_i,
    output logic [W_WIDTH-1:0]           rd_data_o,
    output logic                         bp_en_o,
    output logic                         bp_zero_o,
    output logic [3:0]                   bp_x_o,
    output logic [22:0]                  bp_final_o,
    output logic [H_WIDTH-1:0]           bp_hidden_o,
    output logic [W_WIDTH-1:0]           bp_w_o,
    input  logic [W_WIDTH-1:0]           bp_w_i,
    input  logic                         bp_done_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int                 IDX_W    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_HIDDEN - 1);
    localparam logic [3:0]         N_EXT    = 4'(N_HIDDEN);
    localparam logic [3:0]         TO_EXT   = 4'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           wait_cnt_q;
    logic                 err_q;
    logic [3:0]           target_q;
    logic [22:0]          final_q;
    logic [H_WIDTH-1:0]   hid_q  [N_HIDDEN];
    logic [W_WIDTH-1:0]   bank_q [N_HIDDEN];

    logic                 start_acc;
    logic                 host_we;
    logic                 dp_we;
    logic                 idx_adv;
    logic                 wait_inc;
    logic                 err_set;
    logic                 timeout_hit;
    logic                 busy;
    logic [H_WIDTH-1:0]   cur_hidden;
    logic [W_WIDTH-1:0]   cur_w;

    assign busy        = (state_q != S_IDLE);
    assign start_acc   = (state_q == S_IDLE) && start_i;
    assign host_we     = (state_q == S_IDLE) && wr_en_i && ({1'b0, wr_addr_i} < N_EXT);
    assign timeout_hit = ((wait_cnt_q + 4'd1) == TO_EXT);
    assign cur_hidden  = hid_q[idx_q];
    assign cur_w       = bank_q[idx_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        bp_en_o   = 1'b0;
        bp_zero_o = 1'b0;
        done_o    = 1'b0;
        dp_we     = 1'b0;
        idx_adv   = 1'b0;
        wait_inc  = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
`ifdef BP_SEQ_SKIP_ZERO_EN
                if (cur_hidden == '0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_adv = 1'b1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    bp_en_o = 1'b1;
                    state_d = S_WAIT;
                end
`else
                bp_en_o = 1'b1;
                state_d = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (bp_done_i) begin
                    dp_we   = 1'b1;
                    state_d = S_CLEAR;
                end else if (timeout_hit) begin
                    err_set = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_CLEAR: begin
                bp_zero_o = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_adv = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            target_q   <= '0;
            final_q    <= '0;
            for (int k = 0; k < N_HIDDEN; k++) hid_q[k] <= '0;
        end else begin
            if (start_acc) begin
                idx_q    <= '0;
                err_q    <= 1'b0;
                target_q <= target_i;
                final_q  <= final_i;
                for (int k = 0; k < N_HIDDEN; k++) hid_q[k] <= hidden_vals_i[k*H_WIDTH +: H_WIDTH];
            end else begin
                if (idx_adv) idx_q <= idx_q + IDX_W'(1);
                if (err_set) err_q <= 1'b1;
            end
            if (state_q != S_WAIT) wait_cnt_q <= '0;
            else if (wait_inc)     wait_cnt_q <= wait_cnt_q + 4'd1;
        end
    end

    // NOTE: the bank is a handful of flops and must read back as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_HIDDEN; k++) bank_q[k] <= '0;
        end else if (host_we) begin
            bank_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
        end else if (dp_we) begin
            bank_q[idx_q] <= bp_w_i;
        end
    end

    assign rd_data_o   = ({1'b0, rd_addr_i} < N_EXT) ? bank_q[rd_addr_i[IDX_W-1:0]] : '0;
    assign busy_o      = busy;
    assign err_o       = err_q;
    assign bp_x_o      = target_q;
    assign bp_final_o  = final_q;
    assign bp_hidden_o = busy ? cur_hidden : '0;
    assign bp_w_o      = busy ? cur_w : '0;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer with a 1-cycle registered w+1 datapath model.
module tb_backprop_sequencer;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 10;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [3:0]     target_i = '0;
    logic [22:0]    final_i = '0;
    logic [N*H-1:0] hidden_vals_i = '0;
    logic           wr_en_i = 1'b0;
    logic [2:0]     wr_addr_i = '0;
    logic [W-1:0]   wr_data_i = '0;
    logic [2:0]     rd_addr_i = '0;
    logic [W-1:0]   rd_data_o;
    logic           bp_en_o, bp_zero_o, busy_o, done_o, err_o;
    logic [3:0]     bp_x_o;
    logic [22:0]    bp_final_o;
    logic [H-1:0]   bp_hidden_o;
    logic [W-1:0]   bp_w_o;
    logic [W-1:0]   bp_w_i = '0;
    logic           bp_done_i = 1'b0;

    int compared = 0;
    int mismatched = 0;

    // Datapath model and pulse counters
    logic           hang_en = 1'b0;
    logic [H-1:0]   hang_val = '0;
    int             en_total = 0;
    int             zero_total = 0;
    int             done_total = 0;

    backprop_sequencer #(.N_HIDDEN(N), .W_WIDTH(W), .H_WIDTH(H), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .target_i(target_i),
        .final_i(final_i), .hidden_vals_i(hidden_vals_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .bp_en_o(bp_en_o), .bp_zero_o(bp_zero_o),
        .bp_x_o(bp_x_o), .bp_final_o(bp_final_o), .bp_hidden_o(bp_hidden_o),
        .bp_w_o(bp_w_o), .bp_w_i(bp_w_i), .bp_done_i(bp_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        bp_done_i <= bp_en_o && !(hang_en && bp_hidden_o == hang_val);
        bp_w_i    <= bp_w_o + 8'd1;
        if (bp_en_o)   en_total   <= en_total + 1;
        if (bp_zero_o) zero_total <= zero_total + 1;
        if (done_o)    done_total <= done_total + 1;
    end

    task automatic check_bank(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] exp_v [4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        for (int a = 0; a < 4; a++) begin
            @(negedge clk_i);
            rd_addr_i = 3'(a);
            #1;
            compared++;
            if (rd_data_o !== exp_v[a]) begin
                $display("FAIL %s bank[%0d]: got %0d expected %0d", name, a, rd_data_o, exp_v[a]);
                mismatched++;
            end
        end
    endtask

    // Starts a pass and checks first-cycle operands, pass length and pulse counts.
    task automatic run_pass(input string name, input logic [N*H-1:0] hid, input logic [W-1:0] exp_w0,
                            input int exp_cyc, input int exp_en, input logic exp_err,
                            input bit busy_wr, input bit with_wr0);
        int cyc;
        int en0, zero0, done0;
        logic [H-1:0] h0;
        bit seen;
        h0 = hid[H-1:0];
        @(negedge clk_i);
        en0 = en_total; zero0 = zero_total; done0 = done_total;
        hidden_vals_i = hid;
        start_i = 1'b1;
        if (with_wr0) begin
            wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 8'd99;
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0;
            wr_en_i = 1'b0;
            if (cyc == 1) begin
                compared++;
                if ({bp_en_o, busy_o, err_o} !== 3'b110) begin
                    $display("FAIL %s issue0 flags {en,busy,err}: got %b expected 110", name, {bp_en_o, busy_o, err_o});
                    mismatched++;
                end
                compared++;
                if ({bp_x_o, bp_final_o, bp_hidden_o, bp_w_o} !== {target_i, final_i, h0, exp_w0}) begin
                    $display("FAIL %s issue0 operands: got x=%0h f=%0h h=%0d w=%0d expected x=%0h f=%0h h=%0d w=%0d",
                             name, bp_x_o, bp_final_o, bp_hidden_o, bp_w_o, target_i, final_i, h0, exp_w0);
                    mismatched++;
                end
            end
            if (busy_wr && cyc == 5) begin
                wr_en_i = 1'b1; wr_addr_i = 3'd3; wr_data_i = 8'd200;
            end
            if (done_o) seen = 1'b1;
        end
        compared++;
        if (!seen || cyc != exp_cyc) begin
            $display("FAIL %s done latency: got %0d cycles (seen=%0d) expected %0d", name, cyc, seen, exp_cyc);
            mismatched++;
        end
        @(negedge clk_i);
        compared++;
        if ({done_o, busy_o, err_o} !== {2'b00, exp_err}) begin
            $display("FAIL %s after pass {done,busy,err}: got %b expected %b", name, {done_o, busy_o, err_o}, {2'b00, exp_err});
            mismatched++;
        end
        compared++;
        if (en_total - en0 != exp_en || zero_total - zero0 != exp_en || done_total - done0 != 1) begin
            $display("FAIL %s pulses en/zero/done: got %0d/%0d/%0d expected %0d/%0d/1",
                     name, en_total - en0, zero_total - zero0, done_total - done0, exp_en, exp_en);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if ({busy_o, done_o, err_o, bp_en_o, bp_zero_o} !== 5'b0) begin
            $display("FAIL reset flags: got %b expected 00000", {busy_o, done_o, err_o, bp_en_o, bp_zero_o});
            mismatched++;
        end
        compared++;
        if ({bp_x_o, bp_final_o, bp_hidden_o, bp_w_o} !== '0) begin
            $display("FAIL reset operands: got %0h expected 0", {bp_x_o, bp_final_o, bp_hidden_o, bp_w_o});
            mismatched++;
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check_bank("reset", 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_bank_write();
        for (int a = 0; a < 4; a++) begin
            @(negedge clk_i);
            wr_en_i = 1'b1; wr_addr_i = 3'(a); wr_data_i = 8'(10 * (a + 1));
        end
        @(negedge clk_i);
        wr_addr_i = 3'd4; wr_data_i = 8'd77;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        check_bank("write", 8'd10, 8'd20, 8'd30, 8'd40);
        @(negedge clk_i);
        rd_addr_i = 3'd6;
        #1;
        compared++;
        if (rd_data_o !== 8'd0) begin
            $display("FAIL read out-of-range: got %0d expected 0", rd_data_o);
            mismatched++;
        end
    endtask

    task automatic test_pass();
        target_i = 4'hA; final_i = 23'h12345;
        run_pass("pass", {10'd4, 10'd3, 10'd2, 10'd1}, 8'd10, 13, 4, 1'b0, 1'b1, 1'b0);
        check_bank("pass", 8'd11, 8'd21, 8'd31, 8'd41);
    endtask

    task automatic test_timeout();
        hang_en = 1'b1; hang_val = 10'd3;
        target_i = 4'h5; final_i = 23'h7ABCD;
        run_pass("timeout", {10'd4, 10'd3, 10'd2, 10'd1}, 8'd11, 16, 4, 1'b1, 1'b0, 1'b0);
        hang_en = 1'b0;
        check_bank("timeout", 8'd12, 8'd22, 8'd31, 8'd42);
        run_pass("err_clear", {10'd4, 10'd3, 10'd2, 10'd1}, 8'd12, 13, 4, 1'b0, 1'b0, 1'b0);
        check_bank("err_clear", 8'd13, 8'd23, 8'd32, 8'd43);
    endtask

    task automatic test_reset_mid();
        int done0;
        @(negedge clk_i);
        done0 = done_total;
        hidden_vals_i = {10'd4, 10'd3, 10'd2, 10'd1};
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        compared++;
        if ({busy_o, bp_en_o, bp_w_o} !== {2'b10, 8'd23}) begin
            $display("FAIL midreset wait n1 {busy,en,w}: got %b/%b/%0d expected 1/0/23", busy_o, bp_en_o, bp_w_o);
            mismatched++;
        end
        rst_i = 1'b1;
        #1;
        compared++;
        if ({busy_o, done_o, err_o, bp_en_o, bp_zero_o, bp_x_o, bp_final_o, bp_hidden_o, bp_w_o} !== '0) begin
            $display("FAIL midreset outputs: got busy=%b done=%b en=%b x=%0h w=%0d expected all 0",
                     busy_o, done_o, bp_en_o, bp_x_o, bp_w_o);
            mismatched++;
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        compared++;
        if (busy_o !== 1'b0 || done_total != done0) begin
            $display("FAIL midreset idle/no-done: got busy=%b done_pulses=%0d expected busy=0 done_pulses=0",
                     busy_o, done_total - done0);
            mismatched++;
        end
        check_bank("midreset", 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_start_write();
        target_i = 4'h3; final_i = 23'h00042;
        run_pass("start_wr", {10'd4, 10'd3, 10'd2, 10'd1}, 8'd99, 13, 4, 1'b0, 1'b0, 1'b1);
        check_bank("start_wr", 8'd100, 8'd1, 8'd1, 8'd1);
    endtask

    task automatic test_skip_zero();
`ifdef BP_SEQ_SKIP_ZERO_EN
        run_pass("skip", {10'd0, 10'd7, 10'd0, 10'd5}, 8'd100, 9, 2, 1'b0, 1'b0, 1'b0);
        check_bank("skip", 8'd101, 8'd1, 8'd2, 8'd1);
`else
        run_pass("noskip", {10'd0, 10'd7, 10'd0, 10'd5}, 8'd100, 13, 4, 1'b0, 1'b0, 1'b0);
        check_bank("noskip", 8'd101, 8'd2, 8'd2, 8'd2);
`endif
    endtask

    initial begin
        test_reset();
        test_bank_write();
        test_pass();
        test_timeout();
        test_reset_mid();
        test_start_write();
        test_skip_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
